// File: rtl/bk_spi_pkg.sv
// Shared types and constants for the USRREG SPI byte shifter.
package bk_spi_pkg;

  localparam int unsigned DIV_DEFAULT = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DIV_CNT_W   = 8;
  localparam int unsigned BIT_CNT_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_xfer.sv
// SPI mode-0 master that shifts one byte per wren rising edge.
// Reports busy on dsr and latches overrun when a request arrives mid-transfer.
module spi_xfer
  import bk_spi_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wren,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              dsr,
  output logic              ovr,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BYTE_W - 1);

  state_t               state_q, state_d;
  logic                 wren_q;
  logic                 wren_edge;
  logic [DIV_CNT_W-1:0] div_q, div_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [BYTE_W-1:0]    tx_q, tx_d;
  logic [BYTE_W-1:0]    rx_q, rx_d;
  logic [BYTE_W-1:0]    dout_d;
  logic                 dsr_d, ovr_d, sclk_d, mosi_d;

  assign wren_edge = wren & ~wren_q;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout;
    dsr_d   = dsr;
    ovr_d   = ovr;
    sclk_d  = sclk;
    mosi_d  = mosi;
    case (state_q)
      IDLE: begin
        if (wren_edge) begin
          tx_d    = din;
          mosi_d  = din[BYTE_W-1];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          dsr_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A request while busy (including the completion cycle) is dropped
        if (wren_edge) ovr_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk;
          if (!sclk) begin
            rx_d = {rx_q[BYTE_W-2:0], miso};
          end else if (bit_q != BIT_LAST) begin
            bit_d  = BIT_CNT_W'(bit_q + 1'b1);
            tx_d   = {tx_q[BYTE_W-2:0], tx_q[BYTE_W-1]};
            mosi_d = tx_q[BYTE_W-2];
          end else begin
            dout_d  = rx_q;
            dsr_d   = 1'b1;
            mosi_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          div_d = DIV_CNT_W'(div_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // wren_q tracks wren even in reset so a held strobe cannot start a transfer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wren_q  <= wren;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout    <= '1;
      dsr     <= 1'b1;
      ovr     <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
    end else begin
      state_q <= state_d;
      wren_q  <= wren;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout    <= dout_d;
      dsr     <= dsr_d;
      ovr     <= ovr_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer.sv
// Self-checking bench for spi_xfer: one DIV=2 and one DIV=1 instance, each with a mode-0 slave model.
module tb_spi_xfer;

  logic       clk;
  logic       reset_n;
  logic       wren;
  logic       sel;
  logic [7:0] din;
  logic       wren_a, wren_b;
  logic [7:0] dout_a, dout_b;
  logic       dsr_a, dsr_b, ovr_a, ovr_b, sclk_a, sclk_b, mosi_a, mosi_b;
  logic       miso_a, miso_b;
  logic [7:0] sl_a, sl_b, cap_a, cap_b;
  int         rises_a, rises_b;
  int         n_tests, n_fail;
  logic [7:0] prev_a, prev_b;

  typedef struct {
    logic       sel;
    logic [7:0] d;
    logic [7:0] s;
    int         hold;
    int         extra;
    logic       exp_ovr;
    logic [7:0] exp_dout;
  } vec_t;

  assign wren_a = wren & ~sel;
  assign wren_b = wren & sel;

  spi_xfer #(.DIV(2)) u_a (
    .clk(clk), .reset_n(reset_n), .wren(wren_a), .din(din), .dout(dout_a),
    .dsr(dsr_a), .ovr(ovr_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_xfer #(.DIV(1)) u_b (
    .clk(clk), .reset_n(reset_n), .wren(wren_b), .din(din), .dout(dout_b),
    .dsr(dsr_b), .ovr(ovr_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slaves: capture mosi on rising sclk, present next bit after falling sclk
  always @(posedge sclk_a) begin rises_a++; cap_a = {cap_a[6:0], mosi_a}; end
  always @(negedge sclk_a) begin sl_a = {sl_a[6:0], 1'b0}; miso_a = sl_a[7]; end
  always @(posedge sclk_b) begin rises_b++; cap_b = {cap_b[6:0], mosi_b}; end
  always @(negedge sclk_b) begin sl_b = {sl_b[6:0], 1'b0}; miso_b = sl_b[7]; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: an edge counts as overrun when it lands inside the busy window
  function automatic logic ref_ovr(input int hold, input int extra, input int div);
    return (extra > hold) && (extra <= 16 * div);
  endfunction

  task automatic run(input vec_t v);
    int div, k, done_k;
    logic [7:0] dsel, prv;
    div = v.sel ? 1 : 2;
    prv = v.sel ? prev_b : prev_a;
    @(negedge clk);
    sel = v.sel;
    din = v.d;
    sl_a = v.s; miso_a = v.s[7]; cap_a = '0; rises_a = 0;
    sl_b = v.s; miso_b = v.s[7]; cap_b = '0; rises_b = 0;
    wren = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(sel ? dsr_b : dsr_a), 32'd0);
    k = 0;
    done_k = 0;
    while (k < 300 && (done_k == 0 || k < v.hold + 4)) begin
      @(negedge clk);
      wren = ((k + 1) < v.hold) || ((k + 1) == v.extra);
      if (k == 2) din = ~v.d;
      @(posedge clk); k++; #1;
      if (k == 8) chk("dout_hold_mid", 32'(sel ? dout_b : dout_a), 32'(prv));
      if (done_k == 0 && (sel ? dsr_b : dsr_a)) done_k = k;
    end
    @(negedge clk);
    wren = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dsel = sel ? cap_b : cap_a;
    chk("latency", 32'(done_k), 32'(16 * div));
    chk("dout", 32'(sel ? dout_b : dout_a), 32'(v.exp_dout));
    chk("mosi_bits", 32'(dsel), 32'(v.d));
    chk("sclk_rises", 32'(sel ? rises_b : rises_a), 32'd8);
    chk("ovr", 32'(sel ? ovr_b : ovr_a), 32'(v.exp_ovr));
    chk("idle_dsr", 32'(sel ? dsr_b : dsr_a), 32'd1);
    chk("idle_sclk_mosi", 32'({sel ? sclk_b : sclk_a, sel ? mosi_b : mosi_a}), 32'b01);
    if (v.sel) prev_b = v.exp_dout; else prev_a = v.exp_dout;
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    n_tests = 0; n_fail = 0;
    sel = 1'b0; wren = 1'b0; din = '0; reset_n = 1'b0;
    miso_a = 1'b0; miso_b = 1'b0; sl_a = '0; sl_b = '0;
    cap_a = '0; cap_b = '0; rises_a = 0; rises_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'({dsr_a, ovr_a, dout_a, sclk_a, mosi_a}), 32'({1'b1, 1'b0, 8'hFF, 1'b0, 1'b1}));
    chk("rst_b", 32'({dsr_b, ovr_b, dout_b, sclk_b, mosi_b}), 32'({1'b1, 1'b0, 8'hFF, 1'b0, 1'b1}));
    @(negedge clk); reset_n = 1'b1;
    prev_a = 8'hFF; prev_b = 8'hFF;

    // sel, din, slave byte, hold, extra-edge cycle, expected ovr, expected dout
    vecs.push_back('{1'b0, 8'hA5, 8'h3C, 1,   0,  1'b0, 8'h3C});
    vecs.push_back('{1'b0, 8'h01, 8'hC3, 100, 0,  1'b0, 8'hC3});
    vecs.push_back('{1'b0, 8'h5A, 8'h96, 1,   10, 1'b1, 8'h96});
    vecs.push_back('{1'b0, 8'h33, 8'h81, 1,   0,  1'b0, 8'h81});
    vecs.push_back('{1'b1, 8'hFF, 8'h00, 1,   0,  1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h12, 8'hE7, 1,   32, 1'b1, 8'hE7});
    vecs.push_back('{1'b1, 8'hC4, 8'h5B, 1,   16, 1'b1, 8'h5B});
    vecs.push_back('{1'b1, 8'h00, 8'hFF, 3,   0,  1'b0, 8'hFF});
    foreach (vecs[i]) run(vecs[i]);

    // Reset in the middle of a transfer, with wren held high across the release
    @(negedge clk);
    sel = 1'b0; din = 8'h6B; sl_a = 8'hD2; miso_a = 1'b1; rises_a = 0; wren = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      wren = 1'b0;
      if (k == 20) begin reset_n = 1'b0; wren = 1'b1; end
      @(posedge clk); #1;
      if (k == 19) chk("busy_before_rst", 32'(dsr_a), 32'd0);
    end
    chk("rst_mid", 32'({dsr_a, sclk_a, mosi_a, dout_a, ovr_a}), 32'({1'b1, 1'b0, 1'b1, 8'hFF, 1'b0}));
    begin
      int r;
      r = rises_a;
      @(negedge clk); reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("no_start_held_wren", 32'(dsr_a), 32'd1);
      chk("no_sclk_after_rst", 32'(rises_a), 32'(r));
    end
    @(negedge clk); wren = 1'b0;
    @(posedge clk);
    prev_a = 8'hFF; prev_b = 8'hFF;
    rv = '{1'b0, 8'h9E, 8'h47, 1, 0, 1'b0, 8'h47};
    run(rv);

    for (int i = 0; i < 12; i++) begin
      int div;
      rv.sel  = 1'($urandom_range(1, 0));
      div     = rv.sel ? 1 : 2;
      rv.d    = 8'($urandom);
      rv.s    = 8'($urandom);
      rv.hold = int'($urandom_range(3, 1));
      rv.extra = ($urandom_range(1, 0) == 1) ? int'($urandom_range(16 * div, rv.hold + 1)) : 0;
      rv.exp_ovr  = ref_ovr(rv.hold, rv.extra, div);
      rv.exp_dout = rv.s;
      run(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
